// File: rtl/fir_pkg.sv
// Shared sizing defaults and FSM state type for the moving-average block.
package fir_pkg;
  localparam int unsigned DATA_W       = 24;
  localparam int unsigned FILTER_WIDTH = 3;
  localparam int unsigned ACC_W        = DATA_W + FILTER_WIDTH;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fir_state_e;
endpackage

// File: rtl/fir_fill_ctr.sv
// Saturating window-fill counter: counts accepted samples up to 2**FILTER_WIDTH,
// raises done on reaching it, and clears synchronously.
module fir_fill_ctr #(
  parameter int unsigned FILTER_WIDTH = fir_pkg::FILTER_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    inc,
  output logic [FILTER_WIDTH:0]   count,
  output logic                    done
);
  localparam int unsigned CNT_W = FILTER_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << FILTER_WIDTH) - 1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      done  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      done  <= 1'b0;
    end else if (inc && !done) begin
      count <= count + CNT_W'(1);
      done  <= (count == LAST);
    end
  end
endmodule

// File: rtl/fir_accum.sv
// Running-sum moving average over the last 2**FILTER_WIDTH accepted samples,
// fed by an external delay line, with a single-entry valid/ready output register.
module fir_accum #(
  parameter int unsigned FILTER_WIDTH = fir_pkg::FILTER_WIDTH,
  parameter int unsigned DATA_W       = fir_pkg::DATA_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic signed [DATA_W-1:0] old_sample,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_avg
);
  localparam int unsigned ACC_W = DATA_W + FILTER_WIDTH;
  localparam int unsigned CNT_W = FILTER_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'((1 << FILTER_WIDTH) - 1);

  fir_pkg::fir_state_e     state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] leaving;
  logic [CNT_W-1:0]        count;
  logic                    done;
  logic                    accept;
  logic                    load;

  fir_fill_ctr #(
    .FILTER_WIDTH(FILTER_WIDTH)
  ) u_fill_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (flush),
    .inc     (accept),
    .count   (count),
    .done    (done)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // While filling, the delay-line tail is not yet part of the window.
  assign leaving  = (state == fir_pkg::RUN) ? ACC_W'(old_sample) : '0;
  assign acc_next = acc + ACC_W'(in_sample) - leaving;

  // Publish on the fill-completing acceptance and on every acceptance afterwards.
  assign load = accept && (done || (count == LAST_FILL));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      state     <= fir_pkg::FILL;
      out_valid <= 1'b0;
      out_avg   <= '0;
    end else if (flush) begin
      acc       <= '0;
      state     <= fir_pkg::FILL;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        acc <= acc_next;
      end
      if (accept && (state == fir_pkg::FILL) && (count == LAST_FILL)) begin
        state <= fir_pkg::RUN;
      end
      if (load) begin
        out_avg   <= DATA_W'(acc_next >>> FILTER_WIDTH);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fir_accum.sv
// Scoreboard bench for fir_accum: a window-of-samples reference model with
// floor division, driven by directed sequences and randomized traffic.
module tb_fir_accum;
  localparam int unsigned FW  = 3;
  localparam int unsigned DW  = 24;
  localparam int          WIN = 1 << FW;

  logic                 clock;
  logic                 reset_n;
  logic                 in_valid;
  logic signed [DW-1:0] in_sample;
  logic signed [DW-1:0] old_sample;
  logic                 in_ready;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_avg;

  fir_accum #(
    .FILTER_WIDTH(FW),
    .DATA_W(DW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .old_sample (old_sample),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_avg    (out_avg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  longint               hist[$];  // samples in the current window, oldest first
  logic signed [63:0]   sb[$];    // expected averages awaiting consumption
  logic                 mv = 1'b0; // expected out_valid

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [63:0] window_avg();
    longint sum = 0;
    longint q;
    foreach (hist[i]) sum += hist[i];
    q = sum / WIN;
    if (sum < 0 && (sum % WIN) != 0) q -= 1;
    return 64'(q);
  endfunction

  // One clock of stimulus; the bench plays the upstream delay line for old_sample.
  task automatic drive(input logic iv, input logic signed [DW-1:0] s,
                       input logic fl, input logic ordy);
    logic exp_ready;
    logic acc;
    logic loaded;
    @(negedge clock);
    in_valid  = iv;
    in_sample = s;
    flush     = fl;
    out_ready = ordy;
    old_sample = (hist.size() >= WIN) ? DW'(hist[0]) : DW'($urandom);
    exp_ready = !mv || ordy;
    #1;
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
    acc = iv && exp_ready && !fl;
    @(posedge clock);
    #1;
    loaded = 1'b0;
    if (fl) begin
      hist.delete();
      sb.delete();
      mv = 1'b0;
    end else begin
      if (acc) begin
        hist.push_back(longint'(s));
        if (hist.size() > WIN) void'(hist.pop_front());
        if (hist.size() == WIN) begin
          sb.push_back(window_avg());
          loaded = 1'b1;
        end
      end
      if (loaded) mv = 1'b1;
      else if (ordy) mv = 1'b0;
    end
  endtask

  task automatic async_reset();
    @(negedge clock);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #3;
    reset_n = 1'b0;
    mv = 1'b0;
    hist.delete();
    sb.delete();
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'sd0);
    check("rst_out_avg", 64'(out_avg), 64'sd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'sd1);
    repeat (2) @(posedge clock);
    #3;
    reset_n = 1'b1;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset_n === 1'b1) begin
        check("out_valid", {63'd0, out_valid}, {63'd0, mv});
        if (out_valid === 1'b1) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got out_avg %0d, expected no output at %0t",
                     out_avg, $time);
          end else begin
            check("out_avg", 64'(out_avg), sb[0]);
            if (out_ready) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_sample  = '0;
    old_sample = '0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    #3;
    check("init_out_valid", {63'd0, out_valid}, 64'sd0);
    check("init_out_avg", 64'(out_avg), 64'sd0);
    check("init_in_ready", {63'd0, in_ready}, 64'sd1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Ramp 1..8 then 9, 10: averages 4, 5, 6.
    for (int i = 1; i <= 10; i++) drive(1'b1, DW'(i), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);

    // Negative window: all -3, then a window summing to -1.
    for (int i = 0; i < WIN; i++) drive(1'b1, -DW'(3), 1'b0, 1'b1);
    drive(1'b1, -DW'(1), 1'b0, 1'b1);
    for (int i = 0; i < WIN - 1; i++) drive(1'b1, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("floor_neg", 64'(out_avg), -64'sd1);

    // Back-pressure: output held, no acceptance, then release.
    drive(1'b1, DW'(100), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(200 + i), 1'b0, 1'b0);
    drive(1'b1, DW'(300), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);

    // Flush in RUN with a simultaneous sample, then refill.
    drive(1'b1, DW'(50), 1'b0, 1'b1);
    drive(1'b1, DW'(77), 1'b1, 1'b1);
    for (int i = 1; i <= WIN + 2; i++) drive(1'b1, DW'(i * 7), 1'b0, 1'b1);

    // Asynchronous reset mid-stream, then refill 1..8.
    async_reset();
    for (int i = 1; i <= WIN; i++) drive(1'b1, DW'(i), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("refill_avg", 64'(out_avg), 64'sd4);

    // Randomized traffic with occasional flush and one reset.
    for (int i = 0; i < 600; i++) begin
      logic iv;
      logic ordy;
      logic fl;
      if (i == 300) async_reset();
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 59) == 0);
      drive(iv, DW'($urandom), fl, ordy);
    end

    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 1'b1);
    check("sb_drained", 64'(sb.size()), 64'sd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
